// File: rtl/ts_qos_pkg.sv
// ts_qos_pkg: shared constants, register map and state encoding for the TS QoS scheduler.
package ts_qos_pkg;
   localparam int TS_PKT_LEN = 188;
   localparam logic [7:0] SYNC_BYTE = 8'h47;
   localparam logic [7:0] NULL_HDR1 = 8'h1F;
   localparam logic [7:0] NULL_HDR2 = 8'hFF;
   localparam logic [7:0] NULL_HDR3 = 8'h10;
   localparam logic [7:0] NULL_FILL = 8'hFF;
   localparam logic [7:0] ADDR_CTRL = 8'h00;
   localparam logic [7:0] ADDR_CH_EN = 8'h04;
   localparam logic [7:0] ADDR_PKT_CNT0 = 8'h10;
   localparam logic [7:0] ADDR_NULL_CNT = 8'h20;
   localparam int CTRL_EN = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_NULL = 2;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND_CH = 2'd1, ST_SEND_NULL = 2'd2} ts_state_e;
   // Null packet: sync, PID 0x1FFF, payload-only adaptation field, then 0xFF stuffing.
   function automatic logic [7:0] null_byte(input logic [7:0] idx);
      return idx == 8'd0 ? SYNC_BYTE : idx == 8'd1 ? NULL_HDR1 : idx == 8'd2 ? NULL_HDR2 :
             idx == 8'd3 ? NULL_HDR3 : NULL_FILL;
   endfunction
endpackage

// File: rtl/ts_ch_arbiter.sv
// ts_ch_arbiter: combinational 4-way grant, round-robin after i_rr_ptr or strict priority (ch0 highest).
module ts_ch_arbiter (
   input  logic [3:0] i_cand,
   input  logic [1:0] i_rr_ptr,
   input  logic       i_mode,
   output logic       o_grant_valid,
   output logic [1:0] o_grant_idx
);
   // Scan from the far end so the nearest candidate is the last assignment.
   always_comb begin
      o_grant_idx = '0;
      for (int k = 4; k >= 1; k--)
         if (!i_mode && i_cand[2'(int'(i_rr_ptr) + k)]) o_grant_idx = 2'(int'(i_rr_ptr) + k);
      for (int i = 3; i >= 0; i--)
         if (i_mode && i_cand[i]) o_grant_idx = 2'(i);
   end
   assign o_grant_valid = |i_cand;
endmodule

// File: rtl/ts_packet_scheduler.sv
// ts_packet_scheduler: per-packet 4-stream TS mux with RR/strict arbitration, null insertion
// and memory-mapped config/counters.
module ts_packet_scheduler
   import ts_qos_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH = 32
) (
   input  logic                         rclk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            pkt_ready,
   output logic [NUM_CH-1:0]            rd_en,
   input  logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
   input  logic                         mm_write_en,
   input  logic                         mm_read_en,
   input  logic [7:0]                   mm_addr,
   input  logic [31:0]                  mm_wdata,
   output logic [31:0]                  mm_rdata,
   output logic                         valid_out,
   output logic                         syn_out,
   output logic [DATA_WIDTH-1:0]        ts_data_out
);
   ts_state_e             r_state;
   logic [7:0]            r_byte_cnt;
   logic [1:0]            r_gnt, r_rr_ptr, r_sel;
   logic [2:0]            r_ctrl;
   logic [NUM_CH-1:0]     r_ch_en, r_rd_en;
   logic                  r_valid, r_syn, r_is_null;
   logic [DATA_WIDTH-1:0] r_null_byte;
   logic [CNT_WIDTH-1:0]  r_pkt_cnt [NUM_CH];
   logic [CNT_WIDTH-1:0]  r_null_cnt;
   logic [31:0]           r_rdata, w_rdata;
   logic [NUM_CH-1:0]     w_cand;
   logic                  w_gv, w_last, w_arb, w_unused;
   logic [1:0]            w_gi;
   logic [DATA_WIDTH-1:0] w_bytes [NUM_CH];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
      assign w_bytes[c] = rd_data[c*DATA_WIDTH +: DATA_WIDTH];
   end

   assign w_cand = r_ctrl[CTRL_EN] ? pkt_ready & r_ch_en : '0;
   assign w_last = r_byte_cnt == 8'(TS_PKT_LEN - 1);
   assign w_arb = r_state == ST_IDLE || w_last;
   assign w_unused = ^mm_wdata[31:4];

   ts_ch_arbiter u_arb (
      .i_cand       (w_cand),
      .i_rr_ptr     (r_rr_ptr),
      .i_mode       (r_ctrl[CTRL_MODE]),
      .o_grant_valid(w_gv),
      .o_grant_idx  (w_gi)
   );

   always_comb begin
      w_rdata = '0;
      if (mm_addr == ADDR_CTRL) w_rdata = {29'd0, r_ctrl};
      if (mm_addr == ADDR_CH_EN) w_rdata = {28'd0, r_ch_en};
      if (mm_addr == ADDR_NULL_CNT) w_rdata = r_null_cnt;
      for (int i = 0; i < NUM_CH; i++)
         if (mm_addr == ADDR_PKT_CNT0 + 8'(4 * i)) w_rdata = r_pkt_cnt[i];
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_byte_cnt <= '0;
         r_gnt <= '0;
         r_rr_ptr <= 2'd3;
         r_sel <= '0;
         r_ctrl <= 3'b001;
         r_ch_en <= '1;
         r_rd_en <= '0;
         r_valid <= 1'b0;
         r_syn <= 1'b0;
         r_is_null <= 1'b0;
         r_null_byte <= '0;
         r_pkt_cnt <= '{default: '0};
         r_null_cnt <= '0;
         r_rdata <= '0;
      end else begin
         if (w_arb) begin
            r_byte_cnt <= '0;
            r_state <= w_gv ? ST_SEND_CH : (r_ctrl[CTRL_EN] && r_ctrl[CTRL_NULL]) ? ST_SEND_NULL : ST_IDLE;
            r_rd_en <= w_gv ? NUM_CH'(1) << w_gi : '0;
            if (w_gv) r_gnt <= w_gi;
            if (w_gv && !r_ctrl[CTRL_MODE]) r_rr_ptr <= w_gi;
         end else begin
            r_byte_cnt <= r_byte_cnt + 8'd1;
         end
         // Output stage lags the FSM by one cycle to line up with the FIFO read latency.
         r_valid <= r_state != ST_IDLE;
         r_syn <= r_state != ST_IDLE && r_byte_cnt == 8'd0;
         r_is_null <= r_state == ST_SEND_NULL;
         r_sel <= r_gnt;
         r_null_byte <= null_byte(r_byte_cnt);
         if (mm_write_en && mm_addr == ADDR_CTRL) r_ctrl <= mm_wdata[2:0];
         if (mm_write_en && mm_addr == ADDR_CH_EN) r_ch_en <= mm_wdata[NUM_CH-1:0];
         for (int i = 0; i < NUM_CH; i++)
            if (mm_write_en && mm_addr == ADDR_PKT_CNT0 + 8'(4 * i)) r_pkt_cnt[i] <= '0;
            else if (r_syn && !r_is_null && r_sel == 2'(i)) r_pkt_cnt[i] <= r_pkt_cnt[i] + CNT_WIDTH'(1);
         if (mm_write_en && mm_addr == ADDR_NULL_CNT) r_null_cnt <= '0;
         else if (r_syn && r_is_null) r_null_cnt <= r_null_cnt + CNT_WIDTH'(1);
         if (mm_read_en) r_rdata <= w_rdata;
      end
   end

   assign rd_en = r_rd_en;
   assign valid_out = r_valid;
   assign syn_out = r_syn;
   assign mm_rdata = r_rdata;
   assign ts_data_out = r_valid ? (r_is_null ? r_null_byte : w_bytes[r_sel]) : '0;
endmodule
